// File: rtl/grid_io_param_bank.sv
// Perimeter I/O tile: NUM_IO pad channels on one config-chain segment with a committed shadow config.
// Define GRID_IO_INPUT_SYNC_EN to turn the registered-input path into a 2-flop synchroniser.

module grid_io_chan (
  input  logic prog_clk,
  input  logic pReset,
  input  logic isol_n,
  input  logic dir,
  input  logic reg_en,
  input  logic soc_in,
  input  logic outpad,
  output logic soc_out,
  output logic soc_dir,
  output logic inpad
);
`ifdef GRID_IO_INPUT_SYNC_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [STAGES-1:0] in_pipe;

  always_ff @(posedge prog_clk) begin
    if (pReset) in_pipe <= '0;
    else        in_pipe <= (in_pipe << 1) | STAGES'(soc_in);
  end

  // Isolation wins over config: pad becomes an input with nothing driven either way.
  assign soc_dir = isol_n ? dir : 1'b1;
  assign soc_out = isol_n & ~dir & outpad;
  assign inpad   = (isol_n & dir) ? (reg_en ? in_pipe[STAGES-1] : soc_in) : 1'b0;
endmodule

module grid_io_param_bank #(
  parameter int NUM_IO   = 4,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  input  logic              ccff_en,
  output logic              ccff_tail,
  output logic              cfg_done,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] io_outpad,
  output logic [NUM_IO-1:0] io_inpad
);
  localparam int TOTAL = NUM_IO * CFG_BITS;
  localparam int CNT_W = $clog2(TOTAL + 1);

  logic [TOTAL-1:0]                   chain, chain_nxt;
  logic [NUM_IO-1:0][CFG_BITS-1:0]    act_cfg;
  logic [CNT_W-1:0]                   cnt, cnt_nxt;
  logic                               done_nxt;

  always_comb begin
    chain_nxt = chain;
    cnt_nxt   = cnt;
    done_nxt  = cfg_done;
    if (ccff_en) begin
      chain_nxt    = chain << 1;
      chain_nxt[0] = ccff_head;
      // A shift after a commit starts a fresh load; the old active cfg stays live.
      if (cfg_done)                     cnt_nxt = CNT_W'(1);
      else if (cnt != CNT_W'(TOTAL))    cnt_nxt = cnt + CNT_W'(1);
      done_nxt = (cnt_nxt == CNT_W'(TOTAL));
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      chain    <= '0;
      act_cfg  <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      chain    <= chain_nxt;
      cnt      <= cnt_nxt;
      cfg_done <= done_nxt;
      if (ccff_en && done_nxt) act_cfg <= chain_nxt;
    end
  end

  assign ccff_tail = chain[TOTAL-1];

  for (genvar k = 0; k < NUM_IO; k++) begin : g_ch
    grid_io_chan u_ch (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .isol_n   (IO_ISOL_N),
      .dir      (act_cfg[k][0]),
      .reg_en   (act_cfg[k][1]),
      .soc_in   (gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k]),
      .outpad   (io_outpad[k]),
      .soc_out  (gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k]),
      .soc_dir  (gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k]),
      .inpad    (io_inpad[k])
    );
  end
endmodule

// File: tb/tb_grid_io_param_bank.sv
// Directed bench for grid_io_param_bank (NUM_IO=4, CFG_BITS=2), hand-computed expectations.
module tb_grid_io_param_bank;
  logic       prog_clk = 1'b0;
  logic       pReset, IO_ISOL_N, ccff_head, ccff_en;
  logic       ccff_tail, cfg_done;
  logic [3:0] soc_in, soc_out, soc_dir, io_outpad, io_inpad;
  int         n_run = 0, n_fail = 0;

`ifdef GRID_IO_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  grid_io_param_bank #(.NUM_IO(4), .CFG_BITS(2)) dut (
    .prog_clk                         (prog_clk),
    .pReset                           (pReset),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_head                        (ccff_head),
    .ccff_en                          (ccff_en),
    .ccff_tail                        (ccff_tail),
    .cfg_done                         (cfg_done),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (soc_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (soc_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (soc_dir),
    .io_outpad                        (io_outpad),
    .io_inpad                         (io_inpad)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk); #1;
  endtask

  task automatic shift(input logic b);
    ccff_en = 1'b1; ccff_head = b;
    tick();
    ccff_en = 1'b0;
  endtask

  task automatic do_reset();
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
  endtask

  // MSB first, so after 8 shifts chain == p
  task automatic load(input logic [7:0] p);
    for (int i = 7; i >= 0; i--) shift(p[i]);
  endtask

  initial begin
    logic [7:0] q;
    pReset = 1'b0; IO_ISOL_N = 1'b1; ccff_head = 1'b0; ccff_en = 1'b0;
    soc_in = 4'h0; io_outpad = 4'h0;
    do_reset();
    soc_in = 4'hF; #1;
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_dir",  soc_dir, 4'h0);
    chk("rst_out",  soc_out, 4'h0);
    chk("rst_inpad", io_inpad, 4'h0);
    chk("rst_tail", ccff_tail, 1'b0);
    soc_in = 4'h0;

    // 1: 0x5A -> dir bits p[6],p[4],p[2],p[0] = 1,1,0,0
    for (int i = 7; i >= 1; i--) shift(q_5a(i));
    chk("t1_done7", cfg_done, 1'b0);
    chk("t1_dir7",  soc_dir, 4'h0);
    shift(q_5a(0));
    chk("t1_done8", cfg_done, 1'b1);
    chk("t1_dir8",  soc_dir, 4'hC);

    // 2/3: ch0 out, ch1 in+reg, ch2 in comb, ch3 out
    load(8'h1C);
    io_outpad = 4'b0001; #1;
    chk("t2_done", cfg_done, 1'b1);
    chk("t2_dir",  soc_dir, 4'b0110);
    chk("t2_out",  soc_out, 4'b0001);
    IO_ISOL_N = 1'b0; soc_in = 4'b0100; #1;
    chk("t2_iso_out", soc_out, 4'h0);
    chk("t2_iso_dir", soc_dir, 4'hF);
    chk("t2_iso_in",  io_inpad, 4'h0);
    IO_ISOL_N = 1'b1; #1;
    chk("t3_comb", io_inpad[2], 1'b1);
    soc_in = 4'h0;
    tick(); tick();
    soc_in[1] = 1'b1; #1;
    chk("t3_reg_c0", io_inpad[1], 1'b0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      soc_in[1] = 1'b0;
      chk($sformatf("t3_reg_c%0d", c), io_inpad[1], (c == LAT));
    end

    // 4: partial reload keeps old active cfg
    load(8'hFF);
    chk("t4_dirF", soc_dir, 4'hF);
    for (int i = 7; i >= 5; i--) shift(q_5a(i));
    chk("t4_done3", cfg_done, 1'b0);
    chk("t4_dir3",  soc_dir, 4'hF);
    for (int i = 4; i >= 1; i--) shift(q_5a(i));
    chk("t4_done7", cfg_done, 1'b0);
    shift(q_5a(0));
    chk("t4_done8", cfg_done, 1'b1);
    chk("t4_dir8",  soc_dir, 4'hC);

    // 5: reset mid-load clears everything, full reload needed
    io_outpad = 4'hF;
    for (int i = 0; i < 4; i++) shift(1'b1);
    io_outpad = 4'h0;
    do_reset();
    chk("t5_done", cfg_done, 1'b0);
    chk("t5_dir",  soc_dir, 4'h0);
    chk("t5_tail", ccff_tail, 1'b0);
    tick();
    chk("t5_tail1", ccff_tail, 1'b0);
    for (int i = 0; i < 7; i++) shift(1'b1);
    chk("t5_done7", cfg_done, 1'b0);
    chk("t5_dir7",  soc_dir, 4'h0);
    shift(1'b1);
    chk("t5_done8", cfg_done, 1'b1);
    chk("t5_dir8",  soc_dir, 4'hF);

    // 6: tail replays the first 8 bits after 8 shifts
    do_reset();
    q = 8'hB3;
    load(q);
    chk("t6_tail0", ccff_tail, q[7]);
    for (int j = 1; j < 8; j++) begin
      shift(1'b0);
      chk($sformatf("t6_tail%0d", j), ccff_tail, q[7-j]);
    end
    shift(1'b0);
    chk("t6_tail8", ccff_tail, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  function automatic logic q_5a(input int i);
    logic [7:0] p;
    p = 8'h5A;
    return p[i];
  endfunction
endmodule
